muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the execute stage, sitting alongside the ALU and fed by the same decoded `Func_in`, `A_in` and `B_in` operands. It owns the HI/LO register pair and implements the 6-bit function codes in the `110xxx` space, which the ALU leaves undecoded. Its read result is muxed into the execute-stage result path. `Busy_out` drives the pipeline stall logic.

---
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair.
// One product/quotient bit per cycle, then a sign fix-up.
module muldiv_unit (
  input  logic        Clk_in,
  input  logic        Rst_n_in,
  input  logic        Start_in,
  input  logic [5:0]  Func_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic [31:0] O_out,
  output logic        Busy_out,
  output logic        Done_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t state, state_nx;

  logic [31:0] hi, lo, opnd;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        is_div, neg_res, neg_rem;
  logic        div_zero, done;

  logic        accept, is_md, is_div_op;
  logic        sgn_a, sgn_b;
  logic [31:0] abs_a, abs_b;

  assign accept    = Start_in
                   && (state == S_IDLE)
                   && (Func_in[5:3] == 3'b110);
  assign is_md     = ~Func_in[2];
  assign is_div_op = Func_in[1];
  assign sgn_a     = ~Func_in[0] & A_in[31];
  assign sgn_b     = ~Func_in[0] & B_in[31];
  assign abs_a     = sgn_a ? (~A_in + 32'd1) : A_in;
  assign abs_b     = sgn_b ? (~B_in + 32'd1) : B_in;

  // Shift-add: acc = {partial product, unconsumed multiplier}.
  logic [32:0] m_sum;
  logic [63:0] m_next;
  assign m_sum  = {1'b0, acc[63:32]}
                + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign m_next = {m_sum, acc[31:1]};

  // Restoring divide: acc = {remainder, dividend/quotient}.
  logic [32:0] d_t, d_sub;
  logic        d_ge;
  logic [63:0] d_next;
  assign d_t    = {acc[63:32], acc[31]};
  assign d_sub  = d_t - {1'b0, opnd};
  assign d_ge   = d_t >= {1'b0, opnd};
  assign d_next = {d_ge ? d_sub[31:0] : d_t[31:0],
                   acc[30:0], d_ge};

  logic [63:0] p_fix;
  logic [31:0] q_fix, r_fix;
  assign p_fix = neg_res ? (~acc + 64'd1) : acc;
  assign q_fix = neg_res ? (~acc[31:0] + 32'd1)
                         : acc[31:0];
  assign r_fix = neg_rem ? (~acc[63:32] + 32'd1)
                         : acc[63:32];

  always_ff @(posedge Clk_in) begin
    if (!Rst_n_in) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept && is_md) state_nx = S_CALC;
      S_CALC: if (cnt == 5'd31)    state_nx = S_FIX;
      S_FIX:                       state_nx = S_IDLE;
      default:                     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_in) begin
    if (!Rst_n_in) begin
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == S_FIX);
      unique case (state)
        S_IDLE: begin
          if (accept && !is_md) begin
            if (Func_in[1:0] == 2'b10) hi <= A_in;
            if (Func_in[1:0] == 2'b11) lo <= A_in;
          end else if (accept) begin
            is_div   <= is_div_op;
            neg_res  <= sgn_a ^ sgn_b;
            neg_rem  <= sgn_a;
            div_zero <= is_div_op && (B_in == 32'd0);
            opnd     <= is_div_op ? abs_b : abs_a;
            acc      <= {32'd0, is_div_op ? abs_a : abs_b};
            cnt      <= '0;
          end
        end
        S_CALC: begin
          acc <= is_div ? d_next : m_next;
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          if (is_div) begin
            hi <= r_fix;
            lo <= div_zero ? 32'hFFFF_FFFF : q_fix;
          end else begin
            hi <= p_fix[63:32];
            lo <= p_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    O_out = '0;
    unique case (Func_in)
      6'b110100: O_out = hi;
      6'b110101: O_out = lo;
      default:   O_out = '0;
    endcase
  end

  assign Busy_out = (state != S_IDLE);
  assign Done_out = done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random
// MULT/DIV traffic against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  func;
  logic [31:0] a, b;
  logic [31:0] o;
  logic        busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  localparam logic [5:0] F_MULT  = 6'b110000;
  localparam logic [5:0] F_MULTU = 6'b110001;
  localparam logic [5:0] F_DIV   = 6'b110010;
  localparam logic [5:0] F_DIVU  = 6'b110011;
  localparam logic [5:0] F_MFHI  = 6'b110100;
  localparam logic [5:0] F_MFLO  = 6'b110101;
  localparam logic [5:0] F_MTHI  = 6'b110110;
  localparam logic [5:0] F_MTLO  = 6'b110111;

  muldiv_unit dut (
    .Clk_in   (clk),
    .Rst_n_in (rst_n),
    .Start_in (start),
    .Func_in  (func),
    .A_in     (a),
    .B_in     (b),
    .O_out    (o),
    .Busy_out (busy),
    .Done_out (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input logic [5:0] f,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    longint      sx, sy, sq, sr;
    logic [63:0] ux, uy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = '0;
    case (f)
      F_MULT:  r = sx * sy;
      F_MULTU: r = ux * uy;
      F_DIV: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      F_DIVU: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else        r = {ux[31:0] % y, ux[31:0] / y};
      end
      default: r = {hi_m, lo_m};
    endcase
    return r;
  endfunction

  task automatic read_hilo(input string tag);
    func = F_MFHI;
    #1 chk({tag, ".hi"}, o, hi_m);
    func = F_MFLO;
    #1 chk({tag, ".lo"}, o, lo_m);
    func = 6'd0;
    #1 chk({tag, ".o0"}, o, 32'd0);
  endtask

  task automatic mt_op(input logic [5:0] f, input logic [31:0] x);
    start = 1'b1;
    func  = f;
    a     = x;
    tick();
    start = 1'b0;
    func  = 6'd0;
    if (f == F_MTHI) hi_m = x;
    else             lo_m = x;
    chk("mt.busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] x, input logic [31:0] y);
    logic [63:0] e;
    int          cyc;
    int          early;
    e     = ref_op(f, x, y);
    start = 1'b1;
    func  = f;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    func  = 6'd0;
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    cyc   = 0;
    early = 0;
    while (!done && cyc < 40) begin
      if (!busy) early++;
      tick();
      cyc++;
    end
    chk({tag, ".lat"}, cyc, 33);
    chk({tag, ".idle"}, early, 0);
    chk({tag, ".nbusy"}, {31'd0, busy}, 32'd0);
    hi_m = e[63:32];
    lo_m = e[31:0];
    read_hilo(tag);
    tick();
    chk({tag, ".pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [5:0]  f;
    logic [31:0] x, y;
    int          dones;
    rst_n = 1'b0;
    start = 1'b0;
    func  = 6'd0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    read_hilo("rst");

    mt_op(F_MTHI, 32'h1234_5678);
    read_hilo("mthi");
    mt_op(F_MTLO, 32'hCAFE_F00D);
    read_hilo("mtlo");

    run_op("mult", F_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("mult.hi", hi_m, 32'hFFFF_FFFF);
    chk("mult.lo", lo_m, 32'hFFFF_FFEB);
    run_op("multu", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div", F_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div.lo", lo_m, 32'hFFFF_FFFD);
    run_op("divu0", F_DIVU, 32'd7, 32'd0);
    run_op("div0", F_DIV, 32'h8000_0005, 32'd0);
    run_op("ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf.lo", lo_m, 32'h8000_0000);
    run_op("mmin", F_MULT, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 24; i++) begin
      f = 6'b110000 | 6'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op("rnd", f, x, y);
    end

    // Issue during busy is ignored, MT* included.
    start = 1'b1;
    func  = F_DIVU;
    a     = 32'd100;
    b     = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1;
    func  = F_MTLO;
    a     = 32'd5;
    tick();
    start = 1'b0;
    func  = 6'd0;
    dones = 0;
    for (int i = 0; i < 40 && dones == 0; i++) begin
      if (done) dones++;
      else      tick();
    end
    chk("ign.done", dones, 1);
    hi_m = 32'd1;
    lo_m = 32'd33;
    read_hilo("ign");

    // Reset mid-operation aborts without writing.
    start = 1'b1;
    func  = F_DIVU;
    a     = 32'd100;
    b     = 32'd3;
    tick();
    start = 1'b0;
    func  = 6'd0;
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    hi_m  = '0;
    lo_m  = '0;
    read_hilo("abort");
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) dones++;
      tick();
    end
    chk("abort.quiet", dones, 0);
    read_hilo("abort2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
